rgmii_rx_sequencer: RTL
=======================

// Module: rgmii_rx_sequencer
// PURPOSE
//  Frame sequencer behind the RGMII receive IDDR stage (rxd[3:0] + rx_ctl, q1=rising, q2=falling).
//  Decodes DV/ER from rx_ctl, assembles bytes (1000: one byte/clk; 10/100: nibble pairs), strips preamble/SFD.
//  Emits payload+FCS as a byte AXI-stream with tlast/tuser; captures RGMII in-band link status between frames.
//  Sits between the rx IDDR instances and the MAC rx FIFO; all logic runs on the rx clk.
// PARAMETERS
//  MAX_LEN     1522  max payload bytes (incl. FCS) after SFD; longer frames are truncated and flagged
//  LEN_WIDTH   11    width of internal byte counter; must hold MAX_LEN+1
// PORTS
//  clk            in   1   rx clock, same clock driving the IDDRs
//  rst            in   1   synchronous, active-high reset
//  rxd_q1         in   4   IDDR q1 of rxd (rising-edge sample)
//  rxd_q2         in   4   IDDR q2 of rxd (falling-edge sample)
//  ctl_q1         in   1   IDDR q1 of rx_ctl (RX_DV)
//  ctl_q2         in   1   IDDR q2 of rx_ctl (RX_DV xor RX_ER)
//  mii_select     in   1   1 = 10/100 nibble mode, 0 = 1000 DDR mode
//  m_axis_tdata   out  8   payload byte
//  m_axis_tvalid  out  1   beat valid; no backpressure (no tready)
//  m_axis_tlast   out  1   last byte of frame
//  m_axis_tuser   out  1   frame bad (valid only with tlast)
//  link_up        out  1   in-band status rxd[0]
//  link_speed     out  2   in-band status rxd[2:1] (00=10,01=100,10=1000)
//  full_duplex    out  1   in-band status rxd[3]
// BEHAVIOUR
//  Decode: dv=ctl_q1, er=ctl_q1^ctl_q2. Inputs registered once (stage s1) before the FSM.
//  Byte: 1000 mode {rxd_q2,rxd_q1} per clk. MII mode: rxd_q1 one nibble/clk, low nibble first; q2 ignored.
//  mii_select latched on IDLE->PREAMBLE; held for the whole frame.
//  States: WAIT_IDLE (reset state) -> IDLE when dv=0 sampled; guarantees no partial frame after reset.
//   IDLE: dv=0,er=0 -> update link_up/link_speed/full_duplex from rxd_q1; dv=1 -> PREAMBLE.
//   PREAMBLE: 0x55 bytes (MII: 0x5 nibbles) stay; 0xD5 (MII: nibble 0x5 then 0xD) -> PAYLOAD, counter=0,
//     next nibble is low nibble of byte 0; any other value -> DROP; dv=0 -> IDLE. Nothing emitted.
//   PAYLOAD: one-byte hold register; byte N emitted when byte N+1 assembled or dv falls.
//     dv falls: held byte emitted with tlast=1 -> IDLE. Zero-byte payload: no beat, -> IDLE.
//     er=1 on any payload cycle sets sticky bad flag; tuser=bad on tlast beat.
//     MII odd nibble count at dv fall: stray nibble discarded, tuser=1.
//     byte MAX_LEN+1 assembled: held byte MAX_LEN emitted with tlast=1,tuser=1 -> DROP.
//   DROP: ignore all until dv=0 -> IDLE.
//  Latency (1000): byte N on tdata exactly 2 clk after byte N+1 (or first dv=0) appears on q inputs.
//  tvalid is a single-cycle pulse per byte; MII mode: at most one beat per 2 clk.
//  Reset values: tdata=0, tvalid=0, tlast=0, tuser=0, link_up=0, link_speed=00, full_duplex=0,
//   counter=0, bad=0, state=WAIT_IDLE. Reset mid-frame: tvalid=0 next cycle; rest of that frame dropped.
//  Counter saturates at MAX_LEN+1; never wraps.
// CONFIGURATION
//  RGMII_RX_SEQ_STATS_EN defined: adds outputs stat_good[31:0], stat_bad[31:0]; +1 on each tlast
//   beat with tuser=0 / tuser=1 respectively; wrap at 2^32; cleared by rst. Preamble-aborted and
//   zero-length frames are not counted.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1000 mode: 7x0x55,0xD5,0x01..0x40 (64B), dv drop -> 64 beats 0x01..0x40, tlast on 0x40, tuser=0.
//  MII mode: same frame as nibbles (low first) -> identical 64 beats, one beat per 2 clk, tuser=0.
//  er pulse on byte 10 of 64B frame -> 64 beats, tuser=1 on tlast; stat_bad=1 if stats enabled.
//  MAX_LEN=64, 100-byte payload -> 64 beats, tlast+tuser on byte 64, no further beats until next frame.
//  Idle ctl=00, rxd=0xD -> link_up=1, link_speed=10, full_duplex=1; preamble 0x55,0x33 -> no beats.
//  rst asserted at payload byte 20 with dv held high -> tvalid=0 next clk, no beats until next frame after dv=0.

Source files
------------

// File: rtl/rgmii_rx_sequencer.sv
// RGMII receive frame sequencer: registers the IDDR outputs, decodes DV/ER, and assembles bytes
// (1000: one per clock, 10/100: nibble pairs). It strips the preamble and SFD, emits payload+FCS
// as a byte stream with tlast/tuser, and captures in-band link status between frames.
// Ports: clk/rst (sync, active-high), rxd_q1/rxd_q2/ctl_q1/ctl_q2 from the IDDRs, mii_select,
//   m_axis_tdata/tvalid/tlast/tuser (no tready), link_up/link_speed/full_duplex.
// Optional: define RGMII_RX_SEQ_STATS_EN to add stat_good/stat_bad frame counters.
module rgmii_rx_sequencer #(
  parameter int MAX_LEN   = 1522,
  parameter int LEN_WIDTH = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       ctl_q1,
  input  logic       ctl_q2,
  input  logic       mii_select,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
`ifdef RGMII_RX_SEQ_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad
`endif
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LIMIT = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] SAT   = LEN_WIDTH'(MAX_LEN + 1);

  // input stage; a pure pipeline register, so left unreset
  logic       s_dv, s_er, s_mii;
  logic [3:0] s_q1, s_q2;

  always_ff @(posedge clk) begin
    s_dv  <= ctl_q1;
    s_er  <= ctl_q1 ^ ctl_q2;
    s_q1  <= rxd_q1;
    s_q2  <= rxd_q2;
    s_mii <= mii_select;
  end

  state_t               state, state_n;
  logic                 mii, mii_n;
  logic                 half, half_n;
  logic [3:0]           low_nib, low_n;
  logic                 seen5, seen5_n;
  logic [7:0]           hold, hold_n;
  logic                 hold_vld, hold_vld_n;
  logic [LEN_WIDTH-1:0] cnt, cnt_n;
  logic                 bad, bad_n;
  logic                 pend, pend_n;
  logic                 pend_user, pend_user_n;
  logic [7:0]           tdata_n;
  logic                 tvalid_n, tlast_n, tuser_n;
  logic                 link_up_n, full_duplex_n;
  logic [1:0]           link_speed_n;

  logic [7:0] g_byte, m_byte, a_byte;
  assign g_byte = {s_q2, s_q1};
  assign m_byte = {s_q1, low_nib};
  assign a_byte = mii ? m_byte : g_byte;

  always_comb begin
    state_n       = state;
    mii_n         = mii;
    half_n        = half;
    low_n         = low_nib;
    seen5_n       = seen5;
    hold_n        = hold;
    hold_vld_n    = hold_vld;
    cnt_n         = cnt;
    bad_n         = bad;
    pend_n        = 1'b0;
    pend_user_n   = pend_user;
    tdata_n       = m_axis_tdata;
    tvalid_n      = 1'b0;
    tlast_n       = 1'b0;
    tuser_n       = 1'b0;
    link_up_n     = link_up;
    link_speed_n  = link_speed;
    full_duplex_n = full_duplex;

    // MII end-of-frame beat is deferred one clock so beats stay two clocks apart
    if (pend) begin
      tvalid_n = 1'b1;
      tdata_n  = hold;
      tlast_n  = 1'b1;
      tuser_n  = pend_user;
    end

    unique case (state)
      WAIT_IDLE: begin
        if (!s_dv) state_n = IDLE;
      end
      IDLE: begin
        if (s_dv) begin
          state_n = PREAMBLE;
          mii_n   = s_mii;
          seen5_n = (s_q1 == 4'h5);
        end else if (!s_er) begin
          link_up_n     = s_q1[0];
          link_speed_n  = s_q1[2:1];
          full_duplex_n = s_q1[3];
        end
      end
      PREAMBLE: begin
        if (!s_dv) begin
          state_n = IDLE;
        end else if (mii) begin
          if (s_q1 == 4'h5) begin
            seen5_n = 1'b1;
          end else if (s_q1 == 4'hD && seen5) begin
            state_n = PAYLOAD;
          end else begin
            state_n = DROP;
          end
        end else begin
          if (g_byte == 8'hD5) begin
            state_n = PAYLOAD;
          end else if (g_byte != 8'h55) begin
            state_n = DROP;
          end
        end
        if (state_n == PAYLOAD) begin
          cnt_n      = '0;
          bad_n      = 1'b0;
          half_n     = 1'b0;
          hold_vld_n = 1'b0;
        end
      end
      PAYLOAD: begin
        if (!s_dv) begin
          state_n    = IDLE;
          hold_vld_n = 1'b0;
          if (hold_vld) begin
            if (mii) begin
              pend_n      = 1'b1;
              pend_user_n = bad | half;
            end else begin
              tvalid_n = 1'b1;
              tdata_n  = hold;
              tlast_n  = 1'b1;
              tuser_n  = bad;
            end
          end
        end else begin
          if (s_er) bad_n = 1'b1;
          if (mii && !half) begin
            low_n  = s_q1;
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (cnt == LIMIT) begin
              // one byte too many: close the frame on the held byte
              tvalid_n   = 1'b1;
              tdata_n    = hold;
              tlast_n    = 1'b1;
              tuser_n    = 1'b1;
              cnt_n      = SAT;
              hold_vld_n = 1'b0;
              state_n    = DROP;
            end else begin
              if (hold_vld) begin
                tvalid_n = 1'b1;
                tdata_n  = hold;
              end
              hold_n     = a_byte;
              hold_vld_n = 1'b1;
              cnt_n      = cnt + 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!s_dv) state_n = IDLE;
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_IDLE;
      mii           <= 1'b0;
      half          <= 1'b0;
      low_nib       <= '0;
      seen5         <= 1'b0;
      hold          <= '0;
      hold_vld      <= 1'b0;
      cnt           <= '0;
      bad           <= 1'b0;
      pend          <= 1'b0;
      pend_user     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      link_up       <= 1'b0;
      link_speed    <= 2'b00;
      full_duplex   <= 1'b0;
    end else begin
      state         <= state_n;
      mii           <= mii_n;
      half          <= half_n;
      low_nib       <= low_n;
      seen5         <= seen5_n;
      hold          <= hold_n;
      hold_vld      <= hold_vld_n;
      cnt           <= cnt_n;
      bad           <= bad_n;
      pend          <= pend_n;
      pend_user     <= pend_user_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      m_axis_tuser  <= tuser_n;
      link_up       <= link_up_n;
      link_speed    <= link_speed_n;
      full_duplex   <= full_duplex_n;
    end
  end

`ifdef RGMII_RX_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (tvalid_n && tlast_n) begin
      if (tuser_n) stat_bad <= stat_bad + 32'd1;
      else         stat_good <= stat_good + 32'd1;
    end
  end
`else
  // frame statistics not built
`endif

endmodule
